// File: rtl/tt_response_checker_if.sv
// Handshake and result bundle between a truth-table stimulus source/bench and tt_response_checker.
// The master drives stimulus and observes the results; the checker is the slave.
interface tt_response_checker_if #(
    parameter int N_IN = 4
);
    logic                   start;
    logic                   stop;
    logic                   vec_valid;
    logic [N_IN-1:0]        vec;
    logic                   f;

    logic                   busy;
    logic                   done;
    logic                   pass;
    logic [N_IN:0]          err_cnt;
    logic [N_IN:0]          dup_cnt;
    logic                   first_err_valid;
    logic [N_IN-1:0]        first_err_vec;
    logic [(2**N_IN)-1:0]   seen;
    logic [(2**N_IN)-1:0]   cap_tt;

    modport master (
        output start, stop, vec_valid, vec, f,
        input  busy, done, pass, err_cnt, dup_cnt, first_err_valid,
               first_err_vec, seen, cap_tt
    );

    modport slave (
        input  start, stop, vec_valid, vec, f,
        output busy, done, pass, err_cnt, dup_cnt, first_err_valid,
               first_err_vec, seen, cap_tt
    );
endinterface

// File: rtl/tt_response_checker.sv
// Samples a combinational DUT output once per applied vector, compares it against a
// golden truth table and records coverage, duplicates, first failure and a pass verdict.
module tt_response_checker #(
    parameter int                  N_IN       = 4,
    parameter logic [2**N_IN-1:0]  EXP_TT     = 16'hA5C3,
    parameter int                  SETTLE_CYC = 2
) (
    input logic                   clk,
    input logic                   rst,
    tt_response_checker_if.slave  bus
);

    localparam int NV = 2**N_IN;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RUN    = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_FINISH = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [3:0] CTR_RELOAD = 4'(SETTLE_CYC - 1);

    logic [2:0]      state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [3:0]      ctr_q, ctr_d;
    logic            done_q, done_d;
    logic [N_IN:0]   err_q, err_d;
    logic [N_IN:0]   dup_q, dup_d;
    logic            fev_q, fev_d;
    logic [N_IN-1:0] fevec_q, fevec_d;
    logic [NV-1:0]   seen_q, seen_d;
    logic [NV-1:0]   cap_q, cap_d;
    logic            clr;

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        ctr_d   = ctr_q;
        done_d  = done_q;
        err_d   = err_q;
        dup_d   = dup_q;
        fev_d   = fev_q;
        fevec_d = fevec_q;
        seen_d  = seen_q;
        cap_d   = cap_q;
        clr     = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    clr     = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.stop) begin
                    state_d = S_FINISH;
                end else if (bus.vec_valid) begin
                    vec_d   = bus.vec;
                    ctr_d   = CTR_RELOAD;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                // A new vector restarts the settle window; the pending sample is dropped.
                if (bus.stop) begin
                    state_d = S_FINISH;
                end else if (bus.vec_valid) begin
                    vec_d = bus.vec;
                    ctr_d = CTR_RELOAD;
                end else if (ctr_q == 4'd0) begin
                    seen_d[vec_q] = 1'b1;
                    cap_d[vec_q]  = bus.f;
                    if (seen_q[vec_q] && (dup_q != '1)) begin
                        dup_d = dup_q + 1'b1;
                    end
                    if (bus.f != EXP_TT[vec_q]) begin
                        if (err_q != '1) begin
                            err_d = err_q + 1'b1;
                        end
                        if (!fev_q) begin
                            fev_d   = 1'b1;
                            fevec_d = vec_q;
                        end
                    end
                    state_d = (&seen_d) ? S_FINISH : S_RUN;
                end else begin
                    ctr_d = ctr_q - 4'd1;
                end
            end
            S_FINISH: begin
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        if (clr) begin
            done_d  = 1'b0;
            err_d   = '0;
            dup_d   = '0;
            fev_d   = 1'b0;
            fevec_d = '0;
            seen_d  = '0;
            cap_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            vec_q   <= '0;
            ctr_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= '0;
            dup_q   <= '0;
            fev_q   <= 1'b0;
            fevec_q <= '0;
            seen_q  <= '0;
            cap_q   <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            ctr_q   <= ctr_d;
            done_q  <= done_d;
            err_q   <= err_d;
            dup_q   <= dup_d;
            fev_q   <= fev_d;
            fevec_q <= fevec_d;
            seen_q  <= seen_d;
            cap_q   <= cap_d;
        end
    end

    assign bus.busy            = (state_q == S_RUN) || (state_q == S_SETTLE);
    assign bus.done            = done_q;
    assign bus.pass            = done_q && (err_q == '0) && (&seen_q);
    assign bus.err_cnt         = err_q;
    assign bus.dup_cnt         = dup_q;
    assign bus.first_err_valid = fev_q;
    assign bus.first_err_vec   = fevec_q;
    assign bus.seen            = seen_q;
    assign bus.cap_tt          = cap_q;

endmodule

// File: tb/tb_tt_response_checker.sv
// Directed bench for tt_response_checker: a vector table for one mixed run plus
// hand-written sequences for reset, full runs, early stop, restart and saturation.
module tb_tt_response_checker;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    logic [15:0] exp_tt = 16'hA5C3;

    always #5 clk = ~clk;

    tt_response_checker_if #(.N_IN(4)) bus ();

    tt_response_checker #(
        .N_IN(4),
        .EXP_TT(16'hA5C3),
        .SETTLE_CYC(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [3:0]  vec;
        logic        f;
        logic [4:0]  err;
        logic [4:0]  dup;
        logic [3:0]  fe_vec;
        logic [15:0] seen;
        logic [15:0] cap;
    } step_t;

    step_t tbl [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Strobe one vector and hold it for four cycles in total; sample lands on the second edge after capture.
    task automatic apply_vec(input logic [3:0] v, input logic fv);
        bus.vec       = v;
        bus.f         = fv;
        bus.vec_valid = 1'b1;
        tick();
        bus.vec_valid = 1'b0;
        repeat (3) tick();
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic do_stop();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        tick();
    endtask

    initial begin
        tbl[0] = '{vec: 4'd2,  f: 1'b0, err: 5'd0, dup: 5'd0, fe_vec: 4'd0, seen: 16'h0004, cap: 16'h0000};
        tbl[1] = '{vec: 4'd6,  f: 1'b0, err: 5'd1, dup: 5'd0, fe_vec: 4'd6, seen: 16'h0044, cap: 16'h0000};
        tbl[2] = '{vec: 4'd2,  f: 1'b1, err: 5'd2, dup: 5'd1, fe_vec: 4'd6, seen: 16'h0044, cap: 16'h0004};
        tbl[3] = '{vec: 4'd15, f: 1'b1, err: 5'd2, dup: 5'd1, fe_vec: 4'd6, seen: 16'h8044, cap: 16'h8004};
        tbl[4] = '{vec: 4'd9,  f: 1'b1, err: 5'd3, dup: 5'd1, fe_vec: 4'd6, seen: 16'h8244, cap: 16'h8204};
        tbl[5] = '{vec: 4'd15, f: 1'b0, err: 5'd4, dup: 5'd2, fe_vec: 4'd6, seen: 16'h8244, cap: 16'h0204};

        rst = 1'b1;
        bus.start = 1'b0; bus.stop = 1'b0; bus.vec_valid = 1'b0; bus.vec = '0; bus.f = 1'b0;
        repeat (2) tick();
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_pass", 32'(bus.pass), 0);
        check("rst_err", 32'(bus.err_cnt), 0);
        check("rst_seen", 32'(bus.seen), 0);
        rst = 1'b0;
        tick();

        // Reset held three cycles while a sample is pending in SETTLE
        pulse_start();
        apply_vec(4'd1, 1'b0);
        bus.vec = 4'd4; bus.vec_valid = 1'b1;
        tick();
        bus.vec_valid = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        check("t1_busy", 32'(bus.busy), 0);
        check("t1_seen", 32'(bus.seen), 0);
        check("t1_err", 32'(bus.err_cnt), 0);
        check("t1_fev", 32'(bus.first_err_valid), 0);
        rst = 1'b0;
        tick();
        check("t1_busy_after", 32'(bus.busy), 0);
        check("t1_done_after", 32'(bus.done), 0);

        // Table-driven mixed run with mismatches and duplicates
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            apply_vec(tbl[i].vec, tbl[i].f);
            check($sformatf("tbl%0d_err", i), 32'(bus.err_cnt), 32'(tbl[i].err));
            check($sformatf("tbl%0d_dup", i), 32'(bus.dup_cnt), 32'(tbl[i].dup));
            check($sformatf("tbl%0d_seen", i), 32'(bus.seen), 32'(tbl[i].seen));
            check($sformatf("tbl%0d_cap", i), 32'(bus.cap_tt), 32'(tbl[i].cap));
            check($sformatf("tbl%0d_fev", i), 32'(bus.first_err_valid), 32'(tbl[i].err != 0));
            check($sformatf("tbl%0d_fevec", i), 32'(bus.first_err_vec), 32'(tbl[i].fe_vec));
        end
        do_stop();
        check("tbl_done", 32'(bus.done), 1);
        check("tbl_pass", 32'(bus.pass), 0);

        // Full clean run
        pulse_start();
        for (int v = 0; v < 16; v++) apply_vec(4'(v), exp_tt[v]);
        check("t2_done", 32'(bus.done), 1);
        check("t2_pass", 32'(bus.pass), 1);
        check("t2_busy", 32'(bus.busy), 0);
        check("t2_err", 32'(bus.err_cnt), 0);
        check("t2_dup", 32'(bus.dup_cnt), 0);
        check("t2_seen", 32'(bus.seen), 32'h0000FFFF);
        check("t2_cap", 32'(bus.cap_tt), 32'h0000A5C3);

        // Full run with f inverted at 5 and 12
        pulse_start();
        for (int v = 0; v < 16; v++) apply_vec(4'(v), exp_tt[v] ^ ((v == 5) || (v == 12)));
        check("t3_err", 32'(bus.err_cnt), 2);
        check("t3_fevec", 32'(bus.first_err_vec), 5);
        check("t3_fev", 32'(bus.first_err_valid), 1);
        check("t3_pass", 32'(bus.pass), 0);
        check("t3_cap", 32'(bus.cap_tt), 32'h0000B5E3);

        // 7 -> 5 and 15 -> 13, then early stop
        pulse_start();
        for (int v = 0; v < 16; v++) begin
            automatic int w = (v == 7) ? 5 : (v == 15) ? 13 : v;
            apply_vec(4'(w), exp_tt[w]);
        end
        check("t4_busy", 32'(bus.busy), 1);
        do_stop();
        check("t4_seen", 32'(bus.seen), 32'h00007F7F);
        check("t4_dup", 32'(bus.dup_cnt), 2);
        check("t4_done", 32'(bus.done), 1);
        check("t4_pass", 32'(bus.pass), 0);

        // Back-to-back vec_valid restarts the settle window
        pulse_start();
        bus.f = 1'b0;
        bus.vec = 4'd3; bus.vec_valid = 1'b1;
        tick();
        bus.vec = 4'd9;
        tick();
        bus.vec_valid = 1'b0;
        repeat (3) tick();
        do_stop();
        check("t5_seen", 32'(bus.seen), 32'h00000200);
        check("t5_dup", 32'(bus.dup_cnt), 0);
        check("t5_err", 32'(bus.err_cnt), 0);

        // stop and vec_valid on the same edge: stop wins
        pulse_start();
        bus.stop = 1'b1; bus.vec = 4'd2; bus.vec_valid = 1'b1;
        tick();
        bus.stop = 1'b0; bus.vec_valid = 1'b0;
        repeat (3) tick();
        check("sv_seen", 32'(bus.seen), 0);
        check("sv_done", 32'(bus.done), 1);

        // f only matters on the sample edge
        pulse_start();
        bus.vec = 4'd6; bus.f = 1'b0; bus.vec_valid = 1'b1;
        tick();
        bus.vec_valid = 1'b0;
        tick();
        bus.f = 1'b1;
        tick();
        bus.f = 1'b0;
        tick();
        check("smp_err_ok", 32'(bus.err_cnt), 0);
        check("smp_cap_ok", 32'(bus.cap_tt), 32'h00000040);
        bus.vec = 4'd8; bus.f = 1'b1; bus.vec_valid = 1'b1;
        tick();
        bus.vec_valid = 1'b0;
        tick();
        bus.f = 1'b0;
        tick();
        bus.f = 1'b1;
        tick();
        check("smp_err_bad", 32'(bus.err_cnt), 1);
        check("smp_fevec", 32'(bus.first_err_vec), 8);
        do_stop();

        // start ignored in RUN, honoured in DONE
        pulse_start();
        apply_vec(4'd0, 1'b1);
        apply_vec(4'd1, 1'b0);
        pulse_start();
        check("t6_busy", 32'(bus.busy), 1);
        check("t6_seen", 32'(bus.seen), 32'h00000003);
        check("t6_err", 32'(bus.err_cnt), 1);
        check("t6_cap", 32'(bus.cap_tt), 32'h00000001);
        do_stop();
        check("t6_done", 32'(bus.done), 1);
        pulse_start();
        check("t6_busy_restart", 32'(bus.busy), 1);
        check("t6_done_clr", 32'(bus.done), 0);
        check("t6_seen_clr", 32'(bus.seen), 0);
        check("t6_err_clr", 32'(bus.err_cnt), 0);
        check("t6_fev_clr", 32'(bus.first_err_valid), 0);

        // Counter saturation: repeated mismatching samples of vector 0
        for (int n = 0; n < 40; n++) apply_vec(4'd0, 1'b0);
        check("sat_err", 32'(bus.err_cnt), 31);
        check("sat_dup", 32'(bus.dup_cnt), 31);
        check("sat_fevec", 32'(bus.first_err_vec), 0);
        check("sat_busy", 32'(bus.busy), 1);
        do_stop();
        check("sat_pass", 32'(bus.pass), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
